// File: rtl/ahb_apb_bridge_mslave.sv
// ahb_apb_bridge_mslave: AHB-Lite slave to APB3 master bridge with parametrised
// slave count, address-slot decode, APB wait states and PSLVERR -> HRESP mapping.
// Optional feature macro: APB_TIMEOUT_EN bounds the ACCESS state to TIMEOUT_CYCLES.
module ahb_apb_bridge_mslave #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_SLAVES     = 16,
   parameter int unsigned SEL_LSB        = 24,
   parameter int unsigned SEL_BITS       = 5,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADYIN,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic [NUM_SLAVES-1:0] PSEL,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic                  PENABLE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int unsigned IDX_MSB = SEL_LSB + SEL_BITS - 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_LATCH, ST_SETUP, ST_ACCESS, ST_DONE, ST_ERR1, ST_ERR2
   } state_t;

   state_t                  state_q, state_d;
   logic [SEL_BITS-1:0]     idx_q, idx_d;
   logic                    hreadyout_d, hresp_d, pwrite_d, penable_d;
   logic [DATA_WIDTH-1:0]   hrdata_d, pwdata_d;
   logic [ADDR_WIDTH-1:0]   paddr_d;
   logic [NUM_SLAVES-1:0]   psel_d;
   logic                    accept_c, in_range_c;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            timeout_c;
   assign timeout_c = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
   // Without the timeout the limit parameter has no consumer.
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

   // HTRANS[0] only distinguishes NONSEQ from SEQ, which the bridge treats alike.
   logic unused_htrans0;
   assign unused_htrans0 = HTRANS[0];

   // New transfer request and slot decode of the latched index.
   assign accept_c   = HSEL & HREADYIN & HTRANS[1];
   assign in_range_c = (32'(idx_q) < NUM_SLAVES);

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      hreadyout_d = HREADYOUT;
      hresp_d     = HRESP;
      hrdata_d    = HRDATA;
      psel_d      = PSEL;
      penable_d   = PENABLE;
      pwrite_d    = PWRITE;
      paddr_d     = PADDR;
      pwdata_d    = PWDATA;
`ifdef APB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            hresp_d = 1'b0;
            if (accept_c) begin
               state_d     = ST_LATCH;
               hreadyout_d = 1'b0;
               paddr_d     = HADDR;
               pwrite_d    = HWRITE;
               idx_d       = HADDR[IDX_MSB:SEL_LSB];
            end else begin
               state_d     = ST_IDLE;
               hreadyout_d = 1'b1;
            end
         end
         ST_LATCH: begin
            pwdata_d = HWDATA;
            if (in_range_c) begin
               state_d = ST_SETUP;
               psel_d  = NUM_SLAVES'(1) << idx_q;
            end else begin
               state_d = ST_ERR1;
               hresp_d = 1'b1;
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         ST_ACCESS: begin
            if (PREADY) begin
               psel_d    = '0;
               penable_d = 1'b0;
               if (PSLVERR) begin
                  state_d = ST_ERR1;
                  hresp_d = 1'b1;
               end else begin
                  state_d     = ST_DONE;
                  hreadyout_d = 1'b1;
                  if (!PWRITE) hrdata_d = PRDATA;
               end
            end
`ifdef APB_TIMEOUT_EN
            else if (timeout_c) begin
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = ST_ERR1;
               hresp_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
`endif
         end
         ST_ERR1: begin
            state_d     = ST_ERR2;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b1;
         end
         default: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b0;
            psel_d      = '0;
            penable_d   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
`ifdef APB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         HREADYOUT <= hreadyout_d;
         HRESP     <= hresp_d;
         HRDATA    <= hrdata_d;
         PSEL      <= psel_d;
         PENABLE   <= penable_d;
         PWRITE    <= pwrite_d;
         PADDR     <= paddr_d;
         PWDATA    <= pwdata_d;
`ifdef APB_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge_mslave.sv
// tb_ahb_apb_bridge_mslave: directed plus randomized checks of the AHB-to-APB bridge
// against a transfer-level reference model (4 APB slots, timeout limit 8).
module tb_ahb_apb_bridge_mslave;

   localparam int unsigned NS = 4;
   localparam int unsigned TO = 8;

   logic        HCLK, HRESET, HSEL, HWRITE, HREADYIN, HREADYOUT, HRESP;
   logic [31:0] HADDR, HWDATA, HRDATA, PADDR, PWDATA, PRDATA;
   logic [1:0]  HTRANS;
   logic [3:0]  PSEL;
   logic        PWRITE, PENABLE, PREADY, PSLVERR;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] m_hrdata;

   ahb_apb_bridge_mslave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS),
      .SEL_LSB(24), .SEL_BITS(5), .TIMEOUT_CYCLES(TO)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT),
      .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE),
      .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Overall guard so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      HSEL = 1'b0; HTRANS = 2'b00; HREADYIN = 1'b1;
   endtask

   task automatic addr_phase(input logic [31:0] addr, input logic wr);
      HSEL = 1'b1; HTRANS = {1'b1, 1'($urandom)}; HADDR = addr; HWRITE = wr; HREADYIN = 1'b1;
   endtask

   // Non-accepting AHB cycles; the bridge must answer zero-wait OKAY.
   task automatic idle(input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         case ($urandom % 3)
            0:       begin HSEL = 1'b0; HTRANS = 2'($urandom); HREADYIN = 1'b1; end
            1:       begin HSEL = 1'b1; HTRANS = {1'b0, 1'($urandom)}; HREADYIN = 1'b1; end
            default: begin HSEL = 1'b1; HTRANS = 2'b10; HREADYIN = 1'b0; end
         endcase
         HADDR = $urandom; PREADY = 1'($urandom); PSLVERR = 1'($urandom);
         @(negedge HCLK);
         if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== 4'b0 || PENABLE !== 1'b0) bad++;
      end
      drive_idle();
      chk("idle_okay", 64'(bad), 64'(0));
   endtask

   // One AHB transfer with a modelled APB slave; returns at the data-phase end cycle.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input int waits, input logic slverr, input logic [31:0] rdata);
      int unsigned idx;
      logic        inr, err, done;
      logic [3:0]  exp_sel;
      int          low, resp_hi, psel_n, pen_n, apb_bad, acc_seen;
      idx     = (addr >> 24) & 32'h1f;
      inr     = (idx < NS);
      err     = !inr || slverr;
      exp_sel = inr ? (4'b0001 << idx) : 4'b0000;
      low = 0; resp_hi = 0; psel_n = 0; pen_n = 0; apb_bad = 0; acc_seen = 0; done = 1'b0;
      addr_phase(addr, wr);
      @(posedge HCLK); #1;
      HWDATA = wdata;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge HCLK);
         if (HRESP === 1'b1) resp_hi++;
         if (PSEL !== 4'b0) begin
            psel_n++;
            if (PSEL !== exp_sel || PADDR !== addr || PWRITE !== wr) apb_bad++;
         end
         if (PENABLE === 1'b1) begin
            pen_n++;
            if (PWDATA !== wdata) apb_bad++;
         end
         if (HREADYOUT === 1'b1) done = 1'b1; else low++;
         if (PSEL !== 4'b0 && PENABLE === 1'b1) begin
            acc_seen++;
            PREADY  = (acc_seen > waits);
            PSLVERR = PREADY ? slverr : 1'($urandom);
            PRDATA  = PREADY ? rdata : $urandom;
         end else begin
            PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
         end
         if (done) drive_idle();
         else begin
            HSEL = 1'($urandom); HTRANS = 2'($urandom); HADDR = $urandom;
            HWRITE = 1'($urandom); HREADYIN = 1'($urandom);
         end
      end
      if (inr && !slverr && !wr) m_hrdata = rdata;
      chk("xfer_done", 64'(done), 64'(1));
      chk("xfer_wait_cycles", 64'(low), 64'(inr ? (3 + waits + (slverr ? 1 : 0)) : 2));
      chk("xfer_hresp_end", 64'(HRESP), 64'(err));
      chk("xfer_hresp_cycles", 64'(resp_hi), 64'(err ? 2 : 0));
      chk("xfer_psel_cycles", 64'(psel_n), 64'(inr ? waits + 2 : 0));
      chk("xfer_penable_cycles", 64'(pen_n), 64'(inr ? waits + 1 : 0));
      chk("xfer_apb_fields", 64'(apb_bad), 64'(0));
      chk("xfer_hrdata", 64'(HRDATA), 64'(m_hrdata));
   endtask

   // Directed sequence followed by randomized traffic.
   initial begin
      int          acc;
      logic [31:0] a;
      HRESET = 1'b1; drive_idle(); HADDR = '0; HWRITE = 1'b0; HWDATA = '0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; m_hrdata = '0;
      repeat (3) @(negedge HCLK);
      chk("rst_hreadyout", 64'(HREADYOUT), 64'(1));
      chk("rst_hresp", 64'(HRESP), 64'(0));
      chk("rst_hrdata", 64'(HRDATA), 64'(0));
      chk("rst_psel", 64'(PSEL), 64'(0));
      chk("rst_penable", 64'(PENABLE), 64'(0));
      chk("rst_pwrite", 64'(PWRITE), 64'(0));
      chk("rst_paddr", 64'(PADDR), 64'(0));
      chk("rst_pwdata", 64'(PWDATA), 64'(0));
      HRESET = 1'b0;
      idle(2);

      xfer(32'h0100_0010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
      idle(1);
      xfer(32'h0300_0004, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678);
      idle(2);
      xfer(32'h0200_0008, 1'b1, 32'hCAFE_F00D, 1, 1'b1, 32'h0);
      xfer(32'h0000_000C, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_5A5A);
      idle(1);
      xfer(32'h0500_0000, 1'b0, 32'h0, 0, 1'b0, 32'hFFFF_FFFF);
      xfer(32'h0500_0000, 1'b1, 32'h1111_2222, 0, 1'b0, 32'h0);
      xfer(32'h0100_0000, 1'b0, 32'h0, 2, 1'b1, 32'h7777_7777);

      for (int t = 0; t < 40; t++) begin
         a = $urandom;
         a[28:24] = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
         xfer(a, 1'($urandom), $urandom, $urandom_range(0, 4),
              ($urandom % 5) == 0, $urandom);
         if ($urandom % 2) idle($urandom_range(1, 3));
      end

      // Synchronous reset while a transfer sits in ACCESS.
      addr_phase(32'h0200_0020, 1'b1);
      @(posedge HCLK); #1;
      HWDATA = 32'h5555_AAAA; drive_idle(); PREADY = 1'b0;
      acc = 0;
      for (int i = 0; i < 10 && acc == 0; i++) begin
         @(negedge HCLK);
         if (PSEL !== 4'b0 && PENABLE === 1'b1) acc++;
      end
      chk("rstacc_reached_access", 64'(acc), 64'(1));
      HRESET = 1'b1;
      @(negedge HCLK);
      m_hrdata = '0;
      chk("rstacc_psel", 64'(PSEL), 64'(0));
      chk("rstacc_penable", 64'(PENABLE), 64'(0));
      chk("rstacc_hreadyout", 64'(HREADYOUT), 64'(1));
      chk("rstacc_hresp", 64'(HRESP), 64'(0));
      chk("rstacc_paddr", 64'(PADDR), 64'(0));
      HRESET = 1'b0;
      xfer(32'h0300_0030, 1'b1, 32'h0BAD_CAFE, 1, 1'b0, 32'h0);
      idle(1);

      // APB slave that never becomes ready.
      addr_phase(32'h0100_0040, 1'b0);
      @(posedge HCLK); #1;
      drive_idle(); PREADY = 1'b0; PSLVERR = 1'b0;
      acc = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge HCLK);
         if (PSEL !== 4'b0 && PENABLE === 1'b1) acc++;
         if (HREADYOUT === 1'b1) break;
      end
`ifdef APB_TIMEOUT_EN
      chk("stall_access_cycles", 64'(acc), 64'(TO));
      chk("stall_hresp", 64'(HRESP), 64'(1));
      chk("stall_psel", 64'(PSEL), 64'(0));
      chk("stall_hrdata", 64'(HRDATA), 64'(m_hrdata));
`else
      chk("stall_access_cycles", 64'(acc), 64'(998));
      chk("stall_hreadyout", 64'(HREADYOUT), 64'(0));
      chk("stall_psel", 64'(PSEL), 64'(4'b0010));
      chk("stall_penable", 64'(PENABLE), 64'(1));
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      m_hrdata = '0;
      chk("stall_rst_hreadyout", 64'(HREADYOUT), 64'(1));
      chk("stall_rst_psel", 64'(PSEL), 64'(0));
`endif
      xfer(32'h0000_0044, 1'b0, 32'h0, 0, 1'b0, 32'h3C3C_C3C3);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
